// File: rtl/spst_mac_sequencer.sv
// Feeds operand pairs to the SPST MAC one at a time and accumulates VEC_LEN products into a sum.
// Define SPST_SEQ_TIMEOUT_EN to add a done watchdog with a sticky err flag.
module spst_mac_sequencer #(
    parameter int unsigned VEC_LEN = 4,
    parameter int unsigned ACC_W   = 40,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic             mac_start,
    output logic [15:0]      mac_a,
    output logic [15:0]      mac_b,
    input  logic             mac_done,
    input  logic [31:0]      mac_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             busy,
    output logic             err
);
    localparam int unsigned CntW = $clog2(VEC_LEN + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_e;

    state_e           state_q, state_d;
    logic [15:0]      a_q, a_d, b_q, b_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;

`ifdef SPST_SEQ_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + CntW'(1);
`ifdef SPST_SEQ_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
`ifdef SPST_SEQ_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            StWait: begin
                // done takes priority over an expiring watchdog in the same cycle
                if (mac_done) begin
                    acc_d   = acc_q + ACC_W'(mac_result);
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == CntW'(VEC_LEN)) ? StOut : StIdle;
                end
`ifdef SPST_SEQ_TIMEOUT_EN
                else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
`endif
            end
            StOut: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SPST_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = (state_q == StIdle);
    assign mac_start = (state_q == StIssue);
    assign out_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);
    assign mac_a     = a_q;
    assign mac_b     = b_q;
    assign out_sum   = acc_q;

endmodule
